// File: rtl/aes_pkg.sv
// Shared definitions for the AES serial loader: block width, legal key sizes
// and the loader FSM encoding.
package aes_pkg;

  localparam int unsigned DATA_W = 128;
  localparam int unsigned NK_128 = 4;
  localparam int unsigned NK_192 = 6;
  localparam int unsigned NK_256 = 8;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT_D,
    SHIFT_K,
    CHECK
  } state_t;

  typedef enum logic {
    CH_DATA,
    CH_KEY
  } chan_t;

  function automatic logic nk_legal(input int unsigned nk);
    return (nk == NK_128) || (nk == NK_192) || (nk == NK_256);
  endfunction

endpackage

// File: rtl/serial_shift_reg.sv
// MSB-first serial shift register with parallel load and a saturating bit
// counter that stops at W+1 so overlong frames stay distinguishable.
module serial_shift_reg #(
  parameter int unsigned W     = 128,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr_cnt,
  input  logic             din,
  input  logic             load,
  input  logic [W-1:0]     load_val,
  output logic [W-1:0]     q,
  output logic             msb,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(W + 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q   <= '0;
      cnt <= '0;
    end else begin
      if (en) begin
        q <= {q[W-2:0], din};
      end else if (load) begin
        q <= load_val;
      end
      if (clr_cnt) begin
        cnt <= '0;
      end else if (en && (cnt != CNT_MAX)) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign msb = q[W-1];

endmodule

// File: rtl/aes_serial_loader.sv
// Serial front end for the AES core: frames data/key over two cs-selected
// shift channels, validates frame length, commits and issues start.
module aes_serial_loader
  import aes_pkg::*;
#(
  parameter int unsigned NK    = 6,
  parameter int unsigned KEY_W = NK * 32,
  parameter int unsigned CNT_W = $clog2(KEY_W + 2)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cs_data,
  input  logic              cs_key,
  input  logic              mosi,
  output logic              miso_data,
  output logic              miso_key,
  output logic [DATA_W-1:0] data_out,
  output logic [KEY_W-1:0]  key_out,
  output logic              start,
  input  logic              core_busy,
  input  logic [DATA_W-1:0] result_in,
  input  logic              result_valid,
  output logic              frame_err,
  output logic              data_valid,
  output logic              key_valid
);

  if (!nk_legal(NK)) begin : g_bad_nk
    $error("aes_serial_loader: NK must be 4, 6 or 8");
  end
  if (KEY_W != NK * 32) begin : g_bad_key_w
    $error("aes_serial_loader: KEY_W must equal NK*32");
  end

  state_t            state;
  chan_t             chan;
  logic [DATA_W-1:0] d_q;
  logic [KEY_W-1:0]  k_q;
  logic [CNT_W-1:0]  d_cnt;
  logic [CNT_W-1:0]  k_cnt;
  logic              both_low;
  logic              enter_d;
  logic              enter_k;
  logic              shift_d;
  logic              shift_k;
  logic              load_d;
  logic              data_ok;
  logic              key_ok;
  logic              issue;

  // A data commit with a held key issues straight from CHECK, so start lands
  // in the same cycle as the commit rather than one IDLE cycle later.
  always_comb begin
    both_low = !cs_data && !cs_key;
    enter_d  = (state == IDLE) && !cs_data && cs_key;
    enter_k  = (state == IDLE) && cs_data && !cs_key;
    shift_d  = (state == SHIFT_D) && !cs_data && cs_key;
    shift_k  = (state == SHIFT_K) && cs_data && !cs_key;
    load_d   = result_valid && (state != SHIFT_D);
    data_ok  = (state == CHECK) && (chan == CH_DATA) && (d_cnt == CNT_W'(DATA_W));
    key_ok   = (state == CHECK) && (chan == CH_KEY) && (k_cnt == CNT_W'(KEY_W));
    issue    = key_valid && !core_busy &&
               (((state == IDLE) && data_valid) || (data_ok && !both_low));
  end

  serial_shift_reg #(
    .W     (DATA_W),
    .CNT_W (CNT_W)
  ) u_data_sr (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (shift_d),
    .clr_cnt  (enter_d),
    .din      (mosi),
    .load     (load_d),
    .load_val (result_in),
    .q        (d_q),
    .msb      (miso_data),
    .cnt      (d_cnt)
  );

  serial_shift_reg #(
    .W     (KEY_W),
    .CNT_W (CNT_W)
  ) u_key_sr (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (shift_k),
    .clr_cnt  (enter_k),
    .din      (mosi),
    .load     (1'b0),
    .load_val ('0),
    .q        (k_q),
    .msb      (miso_key),
    .cnt      (k_cnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      chan       <= CH_DATA;
      data_out   <= '0;
      key_out    <= '0;
      start      <= 1'b0;
      frame_err  <= 1'b0;
      data_valid <= 1'b0;
      key_valid  <= 1'b0;
    end else begin
      start     <= issue;
      frame_err <= result_valid && (state == SHIFT_D);
      if (issue) begin
        data_valid <= 1'b0;
      end
      if (both_low) begin
        state     <= IDLE;
        frame_err <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            if (enter_d) begin
              state <= SHIFT_D;
              chan  <= CH_DATA;
            end else if (enter_k) begin
              state <= SHIFT_K;
              chan  <= CH_KEY;
            end
          end
          SHIFT_D: if (cs_data) state <= CHECK;
          SHIFT_K: if (cs_key) state <= CHECK;
          CHECK: begin
            state <= IDLE;
            if (data_ok) begin
              data_out   <= d_q;
              data_valid <= !issue;
            end else if (key_ok) begin
              key_out   <= k_q;
              key_valid <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_aes_serial_loader.sv
// Scoreboard bench for aes_serial_loader: directed frames push expectations,
// negedge monitors pop and compare on start, frame_err, key commits and miso.
module tb_aes_serial_loader;

  typedef struct {
    int          cyc;
    int          n;
    bit          chk;
    logic [255:0] a;
    logic [255:0] b;
  } exp_t;

  localparam logic [127:0] D1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] D2 = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] D3 = 128'h0123456789abcdeffedcba9876543210;
  localparam logic [127:0] D4 = 128'hdeadbeef00000000cafef00d12345678;
  localparam logic [127:0] D5 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] RES = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] K128 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [191:0] K192 = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;
  localparam logic [191:0] K3 = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
  localparam logic [255:0] K256 =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [255:0] KBAD = 256'h1ffffffffffffffffffffffffffffffff;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         cs_data = 1'b1;
  logic         cs_key = 1'b1;
  logic         cs_k4 = 1'b1;
  logic         cs_k8 = 1'b1;
  logic         mosi = 1'b0;
  logic         core_busy = 1'b0;
  logic [127:0] result_in = '0;
  logic         result_valid = 1'b0;

  logic         miso_data, miso_key, start, frame_err, data_valid, key_valid;
  logic [127:0] data_out;
  logic [191:0] key_out;

  logic         k4_miso_data, k4_miso_key, k4_start, k4_frame_err, k4_data_valid, k4_key_valid;
  logic [127:0] k4_data_out;
  logic [127:0] k4_key_out;
  logic         k8_miso_data, k8_miso_key, k8_start, k8_frame_err, k8_data_valid, k8_key_valid;
  logic [127:0] k8_data_out;
  logic [255:0] k8_key_out;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  exp_t q_start[$];
  exp_t q_err[$];
  exp_t q_key[$];
  exp_t q_miso[$];
  exp_t q_rst[$];
  exp_t q_k4[$];
  exp_t q_e4[$];
  exp_t q_k8[$];

  aes_serial_loader #(.NK(6)) dut (
    .clk(clk), .rst_n(rst_n), .cs_data(cs_data), .cs_key(cs_key), .mosi(mosi),
    .miso_data(miso_data), .miso_key(miso_key), .data_out(data_out), .key_out(key_out),
    .start(start), .core_busy(core_busy), .result_in(result_in),
    .result_valid(result_valid), .frame_err(frame_err), .data_valid(data_valid),
    .key_valid(key_valid)
  );

  aes_serial_loader #(.NK(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .cs_data(1'b1), .cs_key(cs_k4), .mosi(mosi),
    .miso_data(k4_miso_data), .miso_key(k4_miso_key), .data_out(k4_data_out),
    .key_out(k4_key_out), .start(k4_start), .core_busy(1'b0), .result_in(128'h0),
    .result_valid(1'b0), .frame_err(k4_frame_err), .data_valid(k4_data_valid),
    .key_valid(k4_key_valid)
  );

  aes_serial_loader #(.NK(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .cs_data(1'b1), .cs_key(cs_k8), .mosi(mosi),
    .miso_data(k8_miso_data), .miso_key(k8_miso_key), .data_out(k8_data_out),
    .key_out(k8_key_out), .start(k8_start), .core_busy(1'b0), .result_in(128'h0),
    .result_valid(1'b0), .frame_err(k8_frame_err), .data_valid(k8_data_valid),
    .key_valid(k8_key_valid)
  );

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual=event required=no_event", name);
  endtask

  function automatic exp_t mk(input int c, input int n, input bit ck,
                              input logic [255:0] a, input logic [255:0] b);
    exp_t e;
    e.cyc = c;
    e.n   = n;
    e.chk = ck;
    e.a   = a;
    e.b   = b;
    return e;
  endfunction

  // main DUT monitor
  logic [191:0] prev_key = '0;
  logic [255:0] bits = '0;
  int           nb = 0;
  bit           in_d = 0;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      prev_key = key_out;
      in_d = 0;
    end else begin
      if (start === 1'b1) begin
        if (q_start.size() == 0) unexpected("start");
        else begin
          e = q_start.pop_front();
          chk("start_cycle", cyc, e.cyc);
          chk("start_data", data_out, e.a);
          chk("start_key", key_out, e.b);
        end
      end
      if (frame_err === 1'b1) begin
        if (q_err.size() == 0) unexpected("frame_err");
        else begin
          e = q_err.pop_front();
          chk("err_cycle", cyc, e.cyc);
          chk("err_key_kept", key_out, e.a);
          chk("err_data_kept", data_out, e.b[255:128]);
          chk("err_data_valid", data_valid, e.b[0]);
        end
      end
      if (key_out !== prev_key) begin
        if (q_key.size() == 0) unexpected("key_change");
        else begin
          e = q_key.pop_front();
          chk("key_cycle", cyc, e.cyc);
          chk("key_value", key_out, e.a);
          chk("key_valid", key_valid, 1);
        end
      end
      prev_key = key_out;
      if (!cs_data) begin
        if (in_d) begin
          bits = {bits[254:0], miso_data};
          nb++;
        end else begin
          in_d = 1;
          nb = 0;
          bits = '0;
        end
      end else if (in_d) begin
        in_d = 0;
        if (q_miso.size() == 0) unexpected("data_frame");
        else begin
          e = q_miso.pop_front();
          if (e.chk) begin
            chk("miso_len", nb, e.n);
            chk("miso_bits", bits[127:0], e.a);
          end
        end
      end
    end
  end

  // NK=4 / NK=8 key monitors
  logic [127:0] prev_k4 = '0;
  logic [255:0] prev_k8 = '0;
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (k4_frame_err === 1'b1) begin
        if (q_e4.size() == 0) unexpected("k4_frame_err");
        else begin
          e = q_e4.pop_front();
          chk("k4_err_cycle", cyc, e.cyc);
          chk("k4_err_key_kept", k4_key_out, e.a);
        end
      end
      if (k4_key_out !== prev_k4) begin
        if (q_k4.size() == 0) unexpected("k4_key_change");
        else begin
          e = q_k4.pop_front();
          chk("k4_key_cycle", cyc, e.cyc);
          chk("k4_key_value", k4_key_out, e.a);
        end
      end
      if (k8_frame_err === 1'b1) unexpected("k8_frame_err");
      if (k8_key_out !== prev_k8) begin
        if (q_k8.size() == 0) unexpected("k8_key_change");
        else begin
          e = q_k8.pop_front();
          chk("k8_key_cycle", cyc, e.cyc);
          chk("k8_key_value", k8_key_out, e.a);
        end
      end
    end
    prev_k4 = k4_key_out;
    prev_k8 = k8_key_out;
  end

  // Asynchronous reset must clear outputs without waiting for a clock edge.
  always @(negedge rst_n) begin
    exp_t e;
    #1;
    if (q_rst.size() == 0) unexpected("reset");
    else begin
      e = q_rst.pop_front();
      chk("rst_data_out", data_out, e.a);
      chk("rst_key_out", key_out, e.a);
      chk("rst_flags", {start, frame_err, data_valid, key_valid, miso_data, miso_key}, e.a);
    end
  end

  task automatic set_cs(input int tgt, input logic v);
    case (tgt)
      0: cs_data = v;
      1: cs_key = v;
      2: cs_k4 = v;
      default: cs_k8 = v;
    endcase
  endtask

  // Entered and left at posedge+1; one no-shift cycle precedes the bits.
  task automatic send(input int tgt, input logic [255:0] v, input int n, output int last);
    set_cs(tgt, 1'b0);
    @(posedge clk); #1;
    for (int i = n - 1; i >= 0; i--) begin
      mosi = v[i];
      @(posedge clk); #1;
    end
    last = cyc;
    set_cs(tgt, 1'b1);
    mosi = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int n;
    int r;
    #2;
    q_rst.push_back(mk(0, 0, 0, '0, '0));
    rst_n = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    send(1, {64'h0, K192}, 192, n);
    q_key.push_back(mk(n + 2, 0, 0, {64'h0, K192}, '0));

    q_miso.push_back(mk(0, 128, 1, '0, '0));
    send(0, {128'h0, D1}, 128, n);
    q_start.push_back(mk(n + 2, 0, 0, {128'h0, D1}, {64'h0, K192}));

    result_in = RES;
    result_valid = 1'b1;
    @(posedge clk); #1;
    result_valid = 1'b0;
    q_miso.push_back(mk(0, 128, 1, {128'h0, RES}, '0));
    send(0, {128'h0, D2}, 128, n);
    q_start.push_back(mk(n + 2, 0, 0, {128'h0, D2}, {64'h0, K192}));

    q_miso.push_back(mk(0, 127, 1, {129'h0, D2[127:1]}, '0));
    send(0, {128'h0, D3}, 127, n);
    q_err.push_back(mk(n + 2, 0, 0, {64'h0, K192}, {D2, 128'h0}));

    send(1, KBAD, 129, n);
    q_err.push_back(mk(n + 2, 0, 0, {64'h0, K192}, {D2, 128'h0}));

    q_miso.push_back(mk(0, 0, 0, '0, '0));
    cs_data = 1'b0;
    cs_key = 1'b0;
    @(posedge clk); #1;
    q_err.push_back(mk(cyc, 0, 0, {64'h0, K192}, {D2, 128'h0}));
    cs_data = 1'b1;
    cs_key = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;

    core_busy = 1'b1;
    q_miso.push_back(mk(0, 128, 1, {128'h0, D2[0], D3[126:0]}, '0));
    send(0, {128'h0, D4}, 128, n);
    repeat (4) @(posedge clk);
    #1;
    core_busy = 1'b0;
    r = cyc;
    q_start.push_back(mk(r + 1, 0, 0, {128'h0, D4}, {64'h0, K192}));
    @(posedge clk); #1;
    @(posedge clk); #1;

    cs_key = 1'b0;
    @(posedge clk); #1;
    for (int i = 191; i > 191 - 90; i--) begin
      mosi = K3[i];
      @(posedge clk); #1;
    end
    q_rst.push_back(mk(0, 0, 0, '0, '0));
    #2 rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    cs_key = 1'b1;
    mosi = 1'b0;
    @(posedge clk); #1;

    send(1, {64'h0, K3}, 192, n);
    q_key.push_back(mk(n + 2, 0, 0, {64'h0, K3}, '0));
    q_miso.push_back(mk(0, 128, 1, '0, '0));
    send(0, {128'h0, D5}, 128, n);
    q_start.push_back(mk(n + 2, 0, 0, {128'h0, D5}, {64'h0, K3}));

    send(2, KBAD, 129, n);
    q_e4.push_back(mk(n + 2, 0, 0, '0, '0));
    send(2, {128'h0, K128}, 128, n);
    q_k4.push_back(mk(n + 2, 0, 0, {128'h0, K128}, '0));
    send(3, K256, 256, n);
    q_k8.push_back(mk(n + 2, 0, 0, K256, '0));

    repeat (6) @(posedge clk);
    #1;
    chk("pending_start", q_start.size(), 0);
    chk("pending_err", q_err.size(), 0);
    chk("pending_key", q_key.size(), 0);
    chk("pending_miso", q_miso.size(), 0);
    chk("pending_rst", q_rst.size(), 0);
    chk("pending_k4", q_k4.size() + q_e4.size(), 0);
    chk("pending_k8", q_k8.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
